// File: rtl/spi_frame_master.sv
// SPI mode-0 master issuing {write, addr, data} register frames to the GPIO expander's slave port.
// Optional define SPI_MISO_SYNC_EN: 2-flop miso synchronizer, miso sampled on the sclk-falling edge.
module spi_frame_master #(
  parameter int ADDR_WIDTH  = 7,
  parameter int PDATA_WIDTH = 8,
  parameter int CLK_DIV     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [PDATA_WIDTH-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [PDATA_WIDTH-1:0] rsp_rdata,
  output logic                   busy,
  output logic                   sclk,
  output logic                   ss,
  output logic                   mosi,
  input  logic                   miso
);

  localparam int FRAME_W = 1 + ADDR_WIDTH + PDATA_WIDTH;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]       BIT_LAST = 5'(FRAME_W);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_frame_master: CLK_DIV must be >= 2");
  end
  if (FRAME_W > 31) begin : g_bad_frame_w
    $error("spi_frame_master: frame does not fit the 5-bit bit counter");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_e;

  state_e                 state_q;
  logic [DIV_W-1:0]       div_q;
  logic [4:0]             bit_cnt_q;
  logic [FRAME_W-1:0]     tx_q;
  logic [PDATA_WIDTH-1:0] rx_q;
  logic [PDATA_WIDTH-1:0] rdata_q;
  logic                   sclk_q;
  logic                   ss_q;
  logic                   ready_q;
  logic                   rsp_valid_q;
  logic                   miso_bit;
  logic                   div_last;

`ifdef SPI_MISO_SYNC_EN
  localparam bit SAMPLE_ON_FALL = 1'b1;
  logic miso_meta_q;
  logic miso_sync_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      miso_meta_q <= miso;
      miso_sync_q <= miso_meta_q;
    end
  end

  assign miso_bit = miso_sync_q;
`else
  localparam bit SAMPLE_ON_FALL = 1'b0;

  assign miso_bit = miso;
`endif

  assign div_last = (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rdata_q     <= '0;
      sclk_q      <= 1'b0;
      ss_q        <= 1'b1;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid && ready_q) begin
            // Read frames carry zero in the data field.
            tx_q      <= {req_write, req_addr, req_wdata & {PDATA_WIDTH{req_write}}};
            ss_q      <= 1'b0;
            ready_q   <= 1'b0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (div_last) begin
            div_q     <= '0;
            sclk_q    <= 1'b1;
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (!SAMPLE_ON_FALL) rx_q <= {rx_q[PDATA_WIDTH-2:0], miso_bit};
            state_q   <= S_SHIFT;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        S_SHIFT: begin
          if (!div_last) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (sclk_q) begin
              sclk_q <= 1'b0;
              tx_q   <= {tx_q[FRAME_W-2:0], 1'b0};
              if (SAMPLE_ON_FALL) rx_q <= {rx_q[PDATA_WIDTH-2:0], miso_bit};
            end else if (bit_cnt_q == BIT_LAST) begin
              // Last low phase done: keep sclk parked low for the hold time.
              state_q <= S_HOLD;
            end else begin
              sclk_q    <= 1'b1;
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (!SAMPLE_ON_FALL) rx_q <= {rx_q[PDATA_WIDTH-2:0], miso_bit};
            end
          end
        end

        S_HOLD: begin
          if (div_last) begin
            div_q       <= '0;
            ss_q        <= 1'b1;
            tx_q        <= '0;
            rsp_valid_q <= 1'b1;
            rdata_q     <= rx_q;
            state_q     <= S_GAP;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        S_GAP: begin
          if (div_last) begin
            div_q   <= '0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign busy      = ~ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign sclk      = sclk_q;
  assign ss        = ss_q;
  assign mosi      = tx_q[FRAME_W-1];

endmodule

// File: tb/tb_spi_frame_master.sv
// Self-checking bench for spi_frame_master: directed frames plus randomized traffic against
// a frame-level model (expected mosi word, slave response byte, cycle counts from the frame rules).
module tb_spi_frame_master;

  localparam int CLK_DIV   = 2;
  localparam int FRAME_CYC = 34 * CLK_DIV;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [6:0] req_addr  = '0;
  logic [7:0] req_wdata = '0;
  logic       miso      = 1'b0;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       sclk;
  logic       ss;
  logic       mosi;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] last_rdata = 8'h00;

  spi_frame_master #(
    .ADDR_WIDTH (7),
    .PDATA_WIDTH(8),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .sclk     (sclk),
    .ss       (ss),
    .mosi     (mosi),
    .miso     (miso)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_sclk"},      sclk,      1'b0);
    check({pfx, "_ss"},        ss,        1'b1);
    check({pfx, "_mosi"},      mosi,      1'b0);
    check({pfx, "_req_ready"}, req_ready, 1'b1);
    check({pfx, "_busy"},      busy,      1'b0);
    check({pfx, "_rsp_valid"}, rsp_valid, 1'b0);
    check({pfx, "_rsp_rdata"}, rsp_rdata, 8'h00);
  endtask

  // Issue one request and act as the SPI slave for it. Entered and left on a falling clk edge.
  // hold_next keeps req_valid high with the next write's fields once this one is accepted.
  task automatic run_frame(input logic wr, input logic [6:0] addr, input logic [7:0] wdata,
                           input logic [15:0] slave_word, input bit hold_next,
                           input logic [6:0] n_addr, input logic [7:0] n_wdata,
                           output int hi_wait);
    logic [15:0] exp_frame;
    logic [15:0] got_frame;
    logic [7:0]  got_rdata;
    logic [7:0]  prev_rdata;
    logic        prev_sclk;
    logic        prev_ss;
    int          budget;
    int          ss_low;
    int          rises;
    int          rsp_idx;
    int          viol;
    int          bitpos;

    exp_frame  = {wr, addr, wr ? wdata : 8'h00};
    prev_rdata = last_rdata;
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wdata;
    hi_wait    = 0;
    budget     = 40 * CLK_DIV + 20;
    while (!req_ready && budget > 0) begin
      @(negedge clk);
      budget--;
      if (ss) hi_wait++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end

    got_frame = '0;
    got_rdata = 8'h00;
    prev_sclk = 1'b0;
    prev_ss   = 1'b1;
    ss_low    = 0;
    rises     = 0;
    rsp_idx   = -1;
    viol      = 0;
    bitpos    = 15;
    for (int idx = 1; idx <= FRAME_CYC + 8 && rsp_idx < 0; idx++) begin
      @(negedge clk);
      if (idx == 1) begin
        check("rdata_hold", rsp_rdata, prev_rdata);
        check("rsp_quiet", rsp_valid, 1'b0);
        if (hold_next) begin
          req_valid = 1'b1;
          req_write = 1'b1;
          req_addr  = n_addr;
          req_wdata = n_wdata;
        end else begin
          req_valid = 1'b0;
          req_write = 1'($urandom);
          req_addr  = 7'($urandom);
          req_wdata = 8'($urandom);
        end
      end
      if (!ss) ss_low++;
      if (ss && mosi) viol++;
      if (busy !== ~req_ready) viol++;
      if (sclk && !prev_sclk) begin
        rises++;
        got_frame = {got_frame[14:0], mosi};
      end
      if (!ss && prev_ss) begin
        miso = slave_word[15];
      end else if (!sclk && prev_sclk) begin
        bitpos--;
        if (bitpos >= 0) miso = slave_word[bitpos];
      end
      if (ss) miso = 1'b0;
      if (rsp_valid) begin
        rsp_idx   = idx;
        got_rdata = rsp_rdata;
      end
      prev_sclk = sclk;
      prev_ss   = ss;
    end

    check("frame_mosi", got_frame, exp_frame);
    check("sclk_rises", rises, 16);
    check("ss_low_cycles", ss_low, FRAME_CYC);
    check("rsp_latency", rsp_idx, FRAME_CYC + 1);
    check("rsp_rdata", got_rdata, slave_word[7:0]);
    check("pin_rules", viol, 0);
    last_rdata = slave_word[7:0];
  endtask

  // Start a read, pull reset mid-frame, and confirm the frame is abandoned cleanly.
  task automatic abort_read(input logic [6:0] addr, input int at_cycle);
    int budget;
    int pulses;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    req_wdata = 8'h00;
    budget    = 40 * CLK_DIV + 20;
    while (!req_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    for (int idx = 1; idx <= at_cycle; idx++) begin
      @(negedge clk);
      if (idx == 1) req_valid = 1'b0;
      miso = 1'($urandom);
    end
    check("abort_mid_frame_ss", ss, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    miso  = 1'b0;
    check_reset_state("abort");
    last_rdata = 8'h00;
    pulses = 0;
    for (int i = 0; i < FRAME_CYC + 10; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("abort_no_rsp", pulses, 0);
  endtask

  initial begin
    int          hw;
    logic        wr;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] sw;

    repeat (2) @(negedge clk);
    check_reset_state("por");
    reset = 1'b0;
    @(negedge clk);

    run_frame(1'b1, 7'h38, 8'hA5, 16'($urandom), 1'b0, 7'h00, 8'h00, hw);
    run_frame(1'b0, 7'h20, 8'h77, {8'($urandom), 8'h3C}, 1'b0, 7'h00, 8'h00, hw);

    run_frame(1'b1, 7'h24, 8'h01, 16'h00C3, 1'b1, 7'h28, 8'h02, hw);
    run_frame(1'b1, 7'h28, 8'h02, 16'h005A, 1'b0, 7'h00, 8'h00, hw);
    check("b2b_ss_gap", hw + 1, CLK_DIV + 1);

    repeat (3) @(negedge clk);
    abort_read(7'h20, 30);
    run_frame(1'b1, 7'h40, 8'hFF, 16'($urandom), 1'b0, 7'h00, 8'h00, hw);

    for (int t = 0; t < 12; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      wr    = 1'($urandom);
      addr  = 7'($urandom);
      wdata = 8'($urandom);
      sw    = 16'($urandom);
      if (t == 0) sw = 16'hFFFF;
      run_frame(wr, addr, wdata, sw, 1'b0, 7'h00, 8'h00, hw);
    end

    repeat (CLK_DIV + 4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("idle_rst");
    reset = 1'b0;
    last_rdata = 8'h00;
    @(negedge clk);
    run_frame(1'b0, 7'h20, 8'h00, 16'h125A, 1'b0, 7'h00, 8'h00, hw);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
